ypc_ctrl: RTL and testbench

YPC_CTRL -- requirements
Module: ypc_ctrl

---
 rtl/ypc_ctrl.sv | 145 ++++++++++++++
 tb/tb_ypc_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ypc_ctrl.sv
// Instruction-sequencing controller for a single-issue core: fetch, decode, execute
// and writeback sequencing with sticky halt on ebreak, illegal opcode, fetch timeout or misaligned PC.
module ypc_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h8000_0000,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        idu_en,
  output logic        exu_en,
  input  logic        exu_done,
  input  logic [31:0] next_pc,
  output logic        wb_en,
  output logic [31:0] pc,
  output logic        halt,
  output logic [2:0]  halt_cause,
  output logic [31:0] instret,
  output logic [2:0]  state_dbg
);

  // Handshakes: imem_req stays high until imem_ready is sampled high at a rising edge;
  // exu_en stays high until exu_done is sampled high. A transfer happens only on that edge.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [31:0] EBREAK    = 32'h0010_0073;
  localparam logic [7:0]  TMO_LIMIT = 8'(MEM_TIMEOUT);

  localparam logic [2:0] CAUSE_EBREAK  = 3'd1;
  localparam logic [2:0] CAUSE_ILLEGAL = 3'd2;
  localparam logic [2:0] CAUSE_TIMEOUT = 3'd3;
  localparam logic [2:0] CAUSE_MISALGN = 3'd4;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [31:0] npc_q;
  logic [31:0] instret_q;
  logic [2:0]  cause_q;
  logic [7:0]  tmo_q;
  logic [7:0]  tmo_d;
  logic        opc_legal;

  assign tmo_d = tmo_q + 8'd1;

  always_comb begin
    opc_legal = 1'b0;
    case (inst_q[6:0])
      7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
      7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011, 7'b1110011: opc_legal = 1'b1;
      default: opc_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      npc_q     <= RESET_PC;
      instret_q <= '0;
      cause_q   <= '0;
      tmo_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run) state_q <= S_FETCH;
        end
        S_FETCH: begin
          // A response arriving on the limit cycle still wins over the timeout.
          if (imem_ready) begin
            inst_q  <= imem_rdata;
            tmo_q   <= '0;
            state_q <= S_DECODE;
          end else if (tmo_d == TMO_LIMIT) begin
            tmo_q   <= tmo_d;
            cause_q <= CAUSE_TIMEOUT;
            state_q <= S_HALT;
          end else begin
            tmo_q <= tmo_d;
          end
        end
        S_DECODE: begin
          if (inst_q == EBREAK) begin
            cause_q <= CAUSE_EBREAK;
            state_q <= S_HALT;
          end else if (!opc_legal) begin
            cause_q <= CAUSE_ILLEGAL;
            state_q <= S_HALT;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (exu_done) begin
            if (next_pc[1:0] != 2'b00) begin
              cause_q <= CAUSE_MISALGN;
              state_q <= S_HALT;
            end else begin
              npc_q   <= next_pc;
              state_q <= S_WB;
            end
          end
        end
        S_WB: begin
          pc_q      <= npc_q;
          instret_q <= instret_q + 32'd1;
          state_q   <= run ? S_FETCH : S_IDLE;
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign imem_req   = (state_q == S_FETCH);
  assign idu_en     = (state_q == S_DECODE);
  assign exu_en     = (state_q == S_EXEC);
  assign wb_en      = (state_q == S_WB);
  assign halt       = (state_q == S_HALT);
  assign halt_cause = cause_q;
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign inst       = inst_q;
  assign instret    = instret_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_ypc_ctrl.sv
// Directed bench for ypc_ctrl: table of single-instruction vectors plus
// hand-written sequences for back-to-back latency and reset during execute.
module tb_ypc_ctrl;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HALT = 3'd5;
  localparam logic [31:0] ADDI   = 32'h0010_0093;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] inst;
  logic        idu_en;
  logic        exu_en;
  logic        exu_done = 1'b0;
  logic [31:0] next_pc = '0;
  logic        wb_en;
  logic [31:0] pc;
  logic        halt;
  logic [2:0]  halt_cause;
  logic [31:0] instret;
  logic [2:0]  state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  ypc_ctrl #(.RESET_PC(32'h8000_0000), .MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .inst(inst), .idu_en(idu_en), .exu_en(exu_en), .exu_done(exu_done), .next_pc(next_pc),
    .wb_en(wb_en), .pc(pc), .halt(halt), .halt_cause(halt_cause), .instret(instret),
    .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          imem_wait;
    logic [31:0] instr;
    int          exu_wait;
    logic [31:0] npc;
    logic        exp_halt;
    logic [2:0]  exp_cause;
    logic [31:0] exp_pc;
    logic [31:0] exp_instret;
    int          exp_fetch;
    int          exp_exec;
    int          exp_wb;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'b0; imem_ready = 1'b0; exu_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic exec_vec(input int idx, input vec_t v);
    int fetch_n = 0;
    int exec_n = 0;
    int wb_n = 0;
    int idu_n = 0;
    int cyc = 0;
    logic [31:0] addr0 = '0;
    logic addr_ok = 1'b1;
    logic done = 1'b0;
    do_reset();
    run = 1'b1;
    imem_rdata = v.instr;
    next_pc = v.npc;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      imem_ready = 1'b0;
      exu_done = 1'b0;
      if (imem_req) begin
        if (fetch_n == 0) addr0 = imem_addr;
        else if (imem_addr !== addr0) addr_ok = 1'b0;
        fetch_n++;
        imem_ready = (fetch_n > v.imem_wait);
      end
      if (idu_en) idu_n++;
      if (exu_en) begin
        exec_n++;
        exu_done = (exec_n > v.exu_wait);
      end
      if (wb_en) begin
        wb_n++;
        run = 1'b0;
        done = 1'b1;
      end
      if (halt) done = 1'b1;
    end
    check("vec_completed", idx, 32'(done), 32'd1);
    // hold start conditions while halted to confirm halt is sticky
    repeat (3) begin
      @(negedge clk);
      if (halt) begin
        run = 1'b1; imem_ready = 1'b1; exu_done = 1'b1;
      end
    end
    check("halt", idx, 32'(halt), 32'(v.exp_halt));
    check("halt_cause", idx, 32'(halt_cause), 32'(v.exp_cause));
    check("pc", idx, pc, v.exp_pc);
    check("instret", idx, instret, v.exp_instret);
    check("state", idx, 32'(state_dbg), v.exp_halt ? 32'(ST_HALT) : 32'(ST_IDLE));
    check("fetch_cycles", idx, 32'(fetch_n), 32'(v.exp_fetch));
    check("idu_cycles", idx, 32'(idu_n), (v.exp_cause == 3'd3) ? 32'd0 : 32'd1);
    check("exec_cycles", idx, 32'(exec_n), 32'(v.exp_exec));
    check("wb_cycles", idx, 32'(wb_n), 32'(v.exp_wb));
    check("addr_stable", idx, 32'(addr_ok), 32'd1);
    check("fetch_addr", idx, addr0, 32'h8000_0000);
    check("enables_low", idx, {28'd0, imem_req, idu_en, exu_en, wb_en}, 32'd0);
  endtask

  initial begin
    int f0;
    int f1;
    int wbs;
    int cyc;

    vecs[0]  = '{0,    ADDI,          0, 32'h8000_0004, 1'b0, 3'd0, 32'h8000_0004, 32'd1, 1,  1, 1};
    vecs[1]  = '{5,    ADDI,          2, 32'h8000_0100, 1'b0, 3'd0, 32'h8000_0100, 32'd1, 6,  3, 1};
    vecs[2]  = '{1000, ADDI,          0, 32'h8000_0004, 1'b1, 3'd3, 32'h8000_0000, 32'd0, 16, 0, 0};
    vecs[3]  = '{0,    32'h0010_0073, 0, 32'h8000_0004, 1'b1, 3'd1, 32'h8000_0000, 32'd0, 1,  0, 0};
    vecs[4]  = '{0,    32'hFFFF_FFFF, 0, 32'h8000_0004, 1'b1, 3'd2, 32'h8000_0000, 32'd0, 1,  0, 0};
    vecs[5]  = '{0,    ADDI,          0, 32'h8000_0006, 1'b1, 3'd4, 32'h8000_0000, 32'd0, 1,  1, 0};
    vecs[6]  = '{15,   ADDI,          0, 32'h8000_0010, 1'b0, 3'd0, 32'h8000_0010, 32'd1, 16, 1, 1};
    vecs[7]  = '{0,    32'h0000_2083, 1, 32'h8000_0008, 1'b0, 3'd0, 32'h8000_0008, 32'd1, 1,  2, 1};
    vecs[8]  = '{0,    32'h0000_000F, 0, 32'h8000_0004, 1'b1, 3'd2, 32'h8000_0000, 32'd0, 1,  0, 0};
    vecs[9]  = '{0,    32'h0000_0073, 0, 32'h8000_0004, 1'b0, 3'd0, 32'h8000_0004, 32'd1, 1,  1, 1};
    vecs[10] = '{16,   ADDI,          0, 32'h8000_0004, 1'b1, 3'd3, 32'h8000_0000, 32'd0, 16, 0, 0};

    // reset state
    do_reset();
    check("rst_state", 0, 32'(state_dbg), 32'(ST_IDLE));
    check("rst_pc", 0, pc, 32'h8000_0000);
    check("rst_inst", 0, inst, 32'd0);
    check("rst_instret", 0, instret, 32'd0);
    check("rst_halt", 0, {28'd0, halt, halt_cause}, 32'd0);
    check("rst_enables", 0, {28'd0, imem_req, idu_en, exu_en, wb_en}, 32'd0);

    for (int i = 0; i < 11; i++) exec_vec(i, vecs[i]);

    // back-to-back instructions: FETCH re-entry exactly 4 cycles after the first FETCH
    do_reset();
    imem_rdata = ADDI; imem_ready = 1'b1; exu_done = 1'b1; run = 1'b1;
    f0 = -1; f1 = -1; wbs = 0; cyc = 0;
    while (wbs < 2 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      next_pc = imem_addr + 32'd4;
      if (imem_req) begin
        if (f0 < 0) f0 = cyc;
        else if (f1 < 0) f1 = cyc;
      end
      if (wb_en) begin
        wbs++;
        if (wbs == 2) run = 1'b0;
      end
    end
    @(negedge clk);
    check("b2b_latency", 0, 32'(f1 - f0), 32'd4);
    check("b2b_pc", 0, pc, 32'h8000_0008);
    check("b2b_instret", 0, instret, 32'd2);
    check("b2b_state", 0, 32'(state_dbg), 32'(ST_IDLE));

    // reset while EXEC is waiting on exu_done
    do_reset();
    imem_rdata = ADDI; imem_ready = 1'b1; exu_done = 1'b0; next_pc = 32'h8000_0004; run = 1'b1;
    cyc = 0;
    while (!exu_en && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("mid_exec_reached", 0, 32'(exu_en), 32'd1);
    rst = 1'b1; run = 1'b1;
    @(negedge clk);
    check("mid_exec_state", 0, 32'(state_dbg), 32'(ST_IDLE));
    check("mid_exec_pc", 0, pc, 32'h8000_0000);
    check("mid_exec_inst", 0, inst, 32'd0);
    check("mid_exec_enables", 0, {28'd0, imem_req, idu_en, exu_en, wb_en}, 32'd0);
    rst = 1'b0; run = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_hold_state", 0, 32'(state_dbg), 32'(ST_IDLE));
    check("idle_hold_req", 0, 32'(imem_req), 32'd0);
    check("idle_hold_instret", 0, instret, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
